// File: rtl/serial_divider_pkg.sv
// Shared definitions for the iterative restoring divider: FSM encoding and counter sizing.
// Imported by the top and available to any future unrolled variant built from div_step.
package serial_divider_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Counter must index WIDTH_N iterations; never narrower than one bit.
   function automatic int cnt_width(input int width_n);
      return (width_n > 1) ? $clog2(width_n) : 1;
   endfunction

endpackage

// File: rtl/serial_divider_div_step.sv
// One combinational restoring-division stage: shift in the next dividend bit, subtract if it fits.
// Pure combinational; latency and flow control belong to the instantiating datapath.
module div_step #(
   parameter int WIDTH_D = 8
) (
   input  logic [WIDTH_D:0]   pr_in,
   input  logic               bit_in,
   input  logic [WIDTH_D-1:0] d,
   output logic [WIDTH_D:0]   pr_out,
   output logic               qbit
);

   logic [WIDTH_D+1:0] shifted;
   logic [WIDTH_D:0]   d_ext;

   // The compare uses the full shifted value; the stored remainder keeps WIDTH_D+1 bits,
   // which is exact whenever d != 0 and reduces to a plain shift when d == 0.
   always_comb begin
      shifted = {pr_in, bit_in};
      d_ext   = {1'b0, d};
      qbit    = (shifted >= {1'b0, d_ext});
      pr_out  = qbit ? (shifted[WIDTH_D:0] - d_ext) : shifted[WIDTH_D:0];
   end

endmodule

// File: rtl/serial_divider.sv
// Iterative unsigned divider, one quotient bit per enabled cycle; done pulses WIDTH_N+1 cycles after the accepted start.
// en=0 stalls everything (state, counter, outputs); start is ignored while busy.
module serial_divider
   import serial_divider_pkg::*;
#(
   parameter int WIDTH_N = 8,
   parameter int WIDTH_D = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               en,
   input  logic               start,
   input  logic [WIDTH_N-1:0] n,
   input  logic [WIDTH_D-1:0] d,
   output logic               busy,
   output logic               done,
   output logic [WIDTH_N-1:0] q,
   output logic [WIDTH_D-1:0] r,
   output logic               div_by_zero
);

   localparam int              CNT_W    = cnt_width(WIDTH_N);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH_N - 1);

   state_t             state;
   logic [CNT_W-1:0]   count;
   logic               last;
   logic [WIDTH_N-1:0] nreg;
   logic [WIDTH_N-1:0] quot;
   logic [WIDTH_D-1:0] dreg;
   logic [WIDTH_D:0]   pr;
   logic [WIDTH_D:0]   pr_next;
   logic               qbit;

   div_step #(
      .WIDTH_D (WIDTH_D)
   ) u_step (
      .pr_in  (pr),
      .bit_in (nreg[WIDTH_N-1]),
      .d      (dreg),
      .pr_out (pr_next),
      .qbit   (qbit)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         count       <= '0;
         last        <= 1'b0;
         nreg        <= '0;
         quot        <= '0;
         dreg        <= '0;
         pr          <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         q           <= '0;
         r           <= '0;
         div_by_zero <= 1'b0;
      end else if (en) begin
         case (state)
            ST_IDLE, ST_DONE: begin
               done <= 1'b0;
               if (start) begin
                  state       <= ST_RUN;
                  busy        <= 1'b1;
                  nreg        <= n;
                  dreg        <= d;
                  pr          <= '0;
                  quot        <= '0;
                  count       <= '0;
                  last        <= 1'b0;
                  div_by_zero <= (d == '0);
               end else begin
                  state <= ST_IDLE;
               end
            end
            ST_RUN: begin
               // The cycle after the final iteration publishes q/r, so partial results never leak out.
               if (last) begin
                  state <= ST_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  q     <= quot;
                  r     <= pr[WIDTH_D-1:0];
                  last  <= 1'b0;
                  count <= '0;
               end else begin
                  pr   <= pr_next;
                  quot <= {quot[WIDTH_N-2:0], qbit};
                  nreg <= {nreg[WIDTH_N-2:0], 1'b0};
                  if (count == LAST_CNT) begin
                     last <= 1'b1;
                  end else begin
                     count <= count + 1'b1;
                  end
               end
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_divider.sv
// Directed and random checks of serial_divider at widths 8/8, 16/5 and 4/7 against an arithmetic model.
module tb_serial_divider;

   typedef struct {
      logic [31:0] q;
      logic [31:0] r;
      logic        dbz;
      int          cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n, en8, en_x;
   logic        start8, start16, start4;
   logic [7:0]  n8, q8;
   logic [7:0]  d8, r8;
   logic [15:0] n16, q16;
   logic [4:0]  d16, r16;
   logic [3:0]  n4, q4;
   logic [6:0]  d4, r4;
   logic        busy8, done8, dbz8, busy16, done16, dbz16, busy4, done4, dbz4;

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   exp_t sb8[$];
   exp_t sb16[$];
   exp_t sb4[$];

   serial_divider #(.WIDTH_N(8), .WIDTH_D(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .en(en8), .start(start8), .n(n8), .d(d8),
      .busy(busy8), .done(done8), .q(q8), .r(r8), .div_by_zero(dbz8));

   serial_divider #(.WIDTH_N(16), .WIDTH_D(5)) dut16 (
      .clk(clk), .rst_n(rst_n), .en(en_x), .start(start16), .n(n16), .d(d16),
      .busy(busy16), .done(done16), .q(q16), .r(r16), .div_by_zero(dbz16));

   serial_divider #(.WIDTH_N(4), .WIDTH_D(7)) dut4 (
      .clk(clk), .rst_n(rst_n), .en(en_x), .start(start4), .n(n4), .d(d4),
      .busy(busy4), .done(done4), .q(q4), .r(r4), .div_by_zero(dbz4));

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   function automatic exp_t model(input int wn, input int wd, input logic [31:0] nv,
                                  input logic [31:0] dv, input int ec);
      exp_t e;
      e.dbz = (dv == 0);
      e.q   = (dv == 0) ? ((32'd1 << wn) - 32'd1) : nv / dv;
      e.r   = (dv == 0) ? nv % (32'd1 << wd) : nv % dv;
      e.cyc = ec;
      return e;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   task automatic step(input int k);
      repeat (k) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Called just after an edge; the start is accepted on the next edge.
   task automatic do_start8(input logic [7:0] nv, input logic [7:0] dv, input int stalls,
                            input bit track);
      n8 = nv;
      d8 = dv;
      start8 = 1'b1;
      if (track) sb8.push_back(model(8, 8, 32'(nv), 32'(dv), cyc + 10 + stalls));
      step(1);
      start8 = 1'b0;
   endtask

   task automatic wait_all(input int limit);
      for (int i = 0; i < limit; i++) begin
         if (sb8.size() == 0 && sb16.size() == 0 && sb4.size() == 0) break;
         step(1);
      end
      chk("drain_timeout", 32'(sb8.size() + sb16.size() + sb4.size()), 32'd0);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (rst_n && done8 && en8) begin
         chk("spurious_done8", 32'(sb8.size() != 0), 32'd1);
         if (sb8.size() != 0) begin
            e = sb8.pop_front();
            chk("q8", 32'(q8), e.q);
            chk("r8", 32'(r8), e.r);
            chk("dbz8", 32'(dbz8), 32'(e.dbz));
            chk("latency8", 32'(cyc), 32'(e.cyc));
         end
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (rst_n && done16 && en_x) begin
         chk("spurious_done16", 32'(sb16.size() != 0), 32'd1);
         if (sb16.size() != 0) begin
            e = sb16.pop_front();
            chk("q16", 32'(q16), e.q);
            chk("r16", 32'(r16), e.r);
            chk("dbz16", 32'(dbz16), 32'(e.dbz));
            chk("latency16", 32'(cyc), 32'(e.cyc));
         end
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (rst_n && done4 && en_x) begin
         chk("spurious_done4", 32'(sb4.size() != 0), 32'd1);
         if (sb4.size() != 0) begin
            e = sb4.pop_front();
            chk("q4", 32'(q4), e.q);
            chk("r4", 32'(r4), e.r);
            chk("dbz4", 32'(dbz4), 32'(e.dbz));
            chk("latency4", 32'(cyc), 32'(e.cyc));
         end
      end
   end

   initial begin
      rst_n = 1'b0;
      en8 = 1'b1;  en_x = 1'b1;
      start8 = 1'b0; start16 = 1'b0; start4 = 1'b0;
      n8 = '0; d8 = '0; n16 = '0; d16 = '0; n4 = '0; d4 = '0;
      step(2);
      chk("rst_busy", 32'(busy8), 32'd0);
      chk("rst_done", 32'(done8), 32'd0);
      chk("rst_q", 32'(q8), 32'd0);
      chk("rst_r", 32'(r8), 32'd0);
      chk("rst_dbz", 32'(dbz8 | busy16 | busy4), 32'd0);
      rst_n = 1'b1;
      step(1);

      // 200 / 7
      do_start8(8'd200, 8'd7, 0, 1'b1);
      chk("t1_busy", 32'(busy8), 32'd1);
      wait_all(30);
      chk("t1_done_pulse", 32'(done8), 32'd0);
      chk("t1_busy_low", 32'(busy8), 32'd0);
      chk("t1_q_held", 32'(q8), 32'd28);
      chk("t1_r_held", 32'(r8), 32'd4);

      // divide by zero
      do_start8(8'd13, 8'd0, 0, 1'b1);
      wait_all(30);
      chk("t2_dbz_held", 32'(dbz8), 32'd1);

      // back-to-back: start held during the DONE cycle
      do_start8(8'd255, 8'd255, 0, 1'b1);
      step(9);
      chk("t3_done_first", 32'(done8), 32'd1);
      do_start8(8'd5, 8'd9, 0, 1'b1);
      chk("t3_busy_no_gap", 32'(busy8), 32'd1);
      chk("t3_done_cleared", 32'(done8), 32'd0);
      wait_all(30);

      // three stalled cycles mid-run
      do_start8(8'd100, 8'd3, 3, 1'b1);
      step(3);
      en8 = 1'b0;
      step(1);
      chk("t4_busy_frozen", 32'(busy8), 32'd1);
      chk("t4_done_frozen", 32'(done8), 32'd0);
      chk("t4_q_frozen", 32'(q8), 32'd0);
      chk("t4_r_frozen", 32'(r8), 32'd5);
      step(2);
      en8 = 1'b1;
      wait_all(30);

      // start during RUN is ignored
      do_start8(8'd77, 8'd10, 0, 1'b1);
      step(3);
      n8 = 8'd50;
      d8 = 8'd5;
      start8 = 1'b1;
      step(1);
      start8 = 1'b0;
      chk("t5_busy_kept", 32'(busy8), 32'd1);
      wait_all(30);

      // done held while en=0 in DONE
      do_start8(8'd40, 8'd6, 2, 1'b1);
      step(9);
      en8 = 1'b0;
      chk("t7_done_up", 32'(done8), 32'd1);
      step(1);
      chk("t7_done_hold1", 32'(done8), 32'd1);
      step(1);
      chk("t7_done_hold2", 32'(done8), 32'd1);
      en8 = 1'b1;
      step(1);
      chk("t7_done_fell", 32'(done8), 32'd0);

      // reset mid-operation
      do_start8(8'd9, 8'd2, 0, 1'b0);
      step(3);
      rst_n = 1'b0;
      #1;
      chk("t6_busy", 32'(busy8), 32'd0);
      chk("t6_done", 32'(done8), 32'd0);
      chk("t6_q", 32'(q8), 32'd0);
      chk("t6_r", 32'(r8), 32'd0);
      step(1);
      rst_n = 1'b1;
      step(1);
      do_start8(8'd250, 8'd16, 0, 1'b1);
      wait_all(30);

      // random sweeps at each width combination
      for (int i = 0; i < 20; i++) begin
         do_start8(8'($urandom), (i % 6 == 0) ? 8'd0 : 8'($urandom), 0, 1'b1);
         wait_all(30);
      end
      for (int i = 0; i < 20; i++) begin
         n16 = 16'($urandom);
         d16 = (i % 5 == 0) ? 5'd0 : 5'($urandom);
         start16 = 1'b1;
         sb16.push_back(model(16, 5, 32'(n16), 32'(d16), cyc + 18));
         step(1);
         start16 = 1'b0;
         wait_all(40);
      end
      for (int i = 0; i < 20; i++) begin
         n4 = 4'($urandom);
         d4 = (i % 5 == 0) ? 7'd0 : 7'($urandom_range(1, 20));
         start4 = 1'b1;
         sb4.push_back(model(4, 7, 32'(n4), 32'(d4), cyc + 6));
         step(1);
         start4 = 1'b0;
         wait_all(20);
      end

      step(2);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
